// File: rtl/axi_aw_w_arbiter.sv
// N:1 AXI4 write-path arbiter: QoS-then-round-robin AW grant into a registered slave stage,
// plus a grant-order FIFO that steers whole W bursts in AW order with no interleaving.
module axi_aw_w_arbiter #(
  parameter int NUM_M    = 4,
  parameter int MIDX_W   = $clog2(NUM_M),
  parameter bit QOS_EN   = 1'b1,
  parameter int WQ_DEPTH = 4
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [NUM_M-1:0]       m_awvalid,
  output logic [NUM_M-1:0]       m_awready,
  input  logic [NUM_M*60-1:0]    m_aw,
  input  logic [NUM_M-1:0]       m_wvalid,
  output logic [NUM_M-1:0]       m_wready,
  input  logic [NUM_M*73-1:0]    m_w,
  output logic                   s_awvalid,
  input  logic                   s_awready,
  output logic [60+MIDX_W-1:0]   s_aw,
  output logic                   s_wvalid,
  input  logic                   s_wready,
  output logic [72:0]            s_w,
  output logic                   wq_full
);
  localparam int AW_W    = 60;
  localparam int W_W     = 73;
  localparam int QOS_LSB = 7;
  localparam int PTR_W   = $clog2(WQ_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  logic                   aw_vld_q;
  logic [AW_W+MIDX_W-1:0] aw_q;
  logic [MIDX_W-1:0]      last_gnt_q;
  logic [MIDX_W-1:0]      wq_mem_q [WQ_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;

  logic [3:0]             max_qos;
  logic [NUM_M-1:0]       cand;
  logic [MIDX_W-1:0]      winner;
  logic                   found;
  int                     rr_idx;
  logic                   can_load;
  logic                   grant;
  logic                   wq_nempty;
  logic                   pop;
  logic [MIDX_W-1:0]      head;

  // Candidate set is narrowed to the top QoS level first, then scanned from last_gnt+1.
  always_comb begin
    max_qos = '0;
    cand    = '0;
    winner  = '0;
    found   = 1'b0;
    rr_idx  = 0;
    for (int i = 0; i < NUM_M; i++) begin
      if (m_awvalid[i] && (m_aw[i*AW_W+QOS_LSB +: 4] > max_qos)) max_qos = m_aw[i*AW_W+QOS_LSB +: 4];
    end
    for (int i = 0; i < NUM_M; i++) begin
      cand[i] = m_awvalid[i] && (!QOS_EN || (m_aw[i*AW_W+QOS_LSB +: 4] == max_qos));
    end
    for (int k = 1; k <= NUM_M; k++) begin
      rr_idx = (int'(last_gnt_q) + k) % NUM_M;
      if (!found && cand[rr_idx]) begin
        winner = MIDX_W'(rr_idx);
        found  = 1'b1;
      end
    end
  end

  assign wq_full   = (cnt_q == CNT_W'(WQ_DEPTH));
  assign can_load  = (!aw_vld_q || s_awready) && !wq_full && !areset;
  assign grant     = can_load && (|m_awvalid);
  assign wq_nempty = (cnt_q != '0) && !areset;
  assign head      = wq_mem_q[rd_ptr_q];
  assign s_awvalid = aw_vld_q;
  assign s_aw      = aw_q;
  assign s_wvalid  = wq_nempty && m_wvalid[head];
  assign s_w       = m_w[head*W_W +: W_W];
  assign pop       = s_wvalid && s_wready && s_w[0];

  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    cnt_d     = cnt_q;
    if (grant) m_awready[winner] = 1'b1;
    if (wq_nempty) m_wready[head] = s_wready;
    case ({grant, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_vld_q   <= 1'b0;
      aw_q       <= '0;
      last_gnt_q <= MIDX_W'(NUM_M - 1);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < WQ_DEPTH; i++) wq_mem_q[i] <= '0;
    end else begin
      if (grant) begin
        aw_vld_q             <= 1'b1;
        aw_q                 <= {winner, m_aw[winner*AW_W +: AW_W]};
        last_gnt_q           <= winner;
        wq_mem_q[wr_ptr_q]   <= winner;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end else if (s_awready) begin
        aw_vld_q <= 1'b0;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_aw_w_arbiter.sv
// Directed bench for axi_aw_w_arbiter: QoS and round-robin instances share all inputs except AW valid.
module tb_axi_aw_w_arbiter;
  logic          aclk = 1'b0;
  logic          areset;
  logic [3:0]    m_awvalid, rr_awvalid;
  logic [239:0]  m_aw;
  logic [3:0]    m_wvalid;
  logic [291:0]  m_w;
  logic          s_awready, s_wready;
  logic [3:0]    m_awready, m_wready, rr_awready, rr_wready;
  logic          s_awvalid, s_wvalid, wq_full, rr_s_awvalid, rr_s_wvalid, rr_wq_full;
  logic [61:0]   s_aw, rr_s_aw;
  logic [72:0]   s_w, rr_s_w;

  int vecs = 0;
  int errs = 0;

  axi_aw_w_arbiter #(.NUM_M(4), .QOS_EN(1'b1), .WQ_DEPTH(4)) dut (
    .aclk(aclk), .areset(areset),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
    .wq_full(wq_full)
  );

  axi_aw_w_arbiter #(.NUM_M(4), .QOS_EN(1'b0), .WQ_DEPTH(4)) dut_rr (
    .aclk(aclk), .areset(areset),
    .m_awvalid(rr_awvalid), .m_awready(rr_awready), .m_aw(m_aw),
    .m_wvalid(m_wvalid), .m_wready(rr_wready), .m_w(m_w),
    .s_awvalid(rr_s_awvalid), .s_awready(s_awready), .s_aw(rr_s_aw),
    .s_wvalid(rr_s_wvalid), .s_wready(s_wready), .s_w(rr_s_w),
    .wq_full(rr_wq_full)
  );

  always #5 aclk = ~aclk;

  function automatic logic [59:0] mk_aw(input logic [3:0] id, input logic [31:0] addr,
                                        input logic [7:0] len, input logic [3:0] qos);
    return {id, addr, len, 3'd3, 2'd1, qos, 4'd0, 3'd0};
  endfunction

  task automatic set_aw(input int m, input logic [59:0] v);
    m_aw[m*60 +: 60] = v;
  endtask

  task automatic set_w(input int m, input logic [63:0] d, input logic last);
    m_w[m*73 +: 73] = {d, 8'hFF, last};
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset     = 1'b1;
    m_awvalid  = '0;
    rr_awvalid = '0;
    m_wvalid   = '0;
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    step();
    step();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    m_aw = '0;
    m_w  = '0;
    for (int m = 0; m < 4; m++) set_aw(m, mk_aw(4'(m), 32'h100 * m, 8'd0, 4'd0));
    areset     = 1'b1;
    m_awvalid  = '1;
    rr_awvalid = '0;
    m_wvalid   = '1;
    s_awready  = 1'b1;
    s_wready   = 1'b1;
    step();
    for (int c = 0; c < 3; c++) begin
      #2;
      vecs++;
      if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0 || m_awready !== 4'b0 || m_wready !== 4'b0 || wq_full !== 1'b0) begin
        errs++;
        $display("FAIL reset_outputs cyc%0d: awv=%b wv=%b awrdy=%b wrdy=%b full=%b, want all 0",
                 c, s_awvalid, s_wvalid, m_awready, m_wready, wq_full);
      end
      step();
    end
    areset = 1'b0;
    #2;
    vecs++;
    if (m_awready !== 4'b0001) begin
      errs++;
      $display("FAIL reset_first_grant: got %b want 0001", m_awready);
    end
  endtask

  task automatic test_round_robin();
    int exp_g [5];
    exp_g = '{0, 1, 2, 3, 0};
    do_reset();
    for (int m = 0; m < 4; m++) begin
      set_aw(m, mk_aw(4'(m + 8), 32'h1000 * m, 8'd0, 4'd0));
      set_w(m, 64'(m + 100), 1'b1);
    end
    m_awvalid = '1;
    m_wvalid  = '1;
    s_awready = 1'b1;
    s_wready  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2;
      vecs++;
      if (m_awready !== 4'(1 << exp_g[k])) begin
        errs++;
        $display("FAIL rr_grant k%0d: got %b want %b", k, m_awready, 4'(1 << exp_g[k]));
      end
      if (k > 0) begin
        vecs++;
        if (s_awvalid !== 1'b1 || s_aw[61:56] !== {2'(exp_g[k-1]), 4'(exp_g[k-1] + 8)}) begin
          errs++;
          $display("FAIL rr_s_aw_id k%0d: vld=%b id=%h want vld=1 id=%h", k, s_awvalid, s_aw[61:56],
                   {2'(exp_g[k-1]), 4'(exp_g[k-1] + 8)});
        end
        vecs++;
        if (m_wready !== 4'(1 << exp_g[k-1]) || s_wvalid !== 1'b1 || s_w[72:9] !== 64'(exp_g[k-1] + 100)) begin
          errs++;
          $display("FAIL rr_w_steer k%0d: wrdy=%b wv=%b data=%0d want wrdy=%b wv=1 data=%0d", k, m_wready,
                   s_wvalid, s_w[72:9], 4'(1 << exp_g[k-1]), exp_g[k-1] + 100);
        end
      end
      step();
    end
    #2;
    vecs++;
    if (s_aw[61:56] !== 6'b00_1000) begin
      errs++;
      $display("FAIL rr_fifth_id: got %h want %h", s_aw[61:56], 6'b00_1000);
    end
    m_awvalid = '0;
    m_wvalid  = '0;
  endtask

  task automatic test_qos();
    int eq [3];
    int er [3];
    logic [3:0] qv, rv;
    eq = '{3, 0, 1};
    er = '{1, 3, 0};
    do_reset();
    m_w = '0;
    set_aw(0, mk_aw(4'd0, 32'h0, 8'd0, 4'd0));
    m_awvalid  = 4'b0001;
    rr_awvalid = 4'b0001;
    s_awready  = 1'b1;
    #2;
    vecs++;
    if (m_awready !== 4'b0001 || rr_awready !== 4'b0001) begin
      errs++;
      $display("FAIL qos_prime: got %b/%b want 0001/0001", m_awready, rr_awready);
    end
    step();
    set_aw(0, mk_aw(4'd0, 32'h10, 8'd0, 4'd9));
    set_aw(1, mk_aw(4'd1, 32'h20, 8'd0, 4'd2));
    set_aw(3, mk_aw(4'd3, 32'h30, 8'd0, 4'd9));
    qv = 4'b1011;
    rv = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      m_awvalid  = qv;
      rr_awvalid = rv;
      #2;
      vecs++;
      if (m_awready !== 4'(1 << eq[k])) begin
        errs++;
        $display("FAIL qos_grant k%0d: got %b want %b", k, m_awready, 4'(1 << eq[k]));
      end
      vecs++;
      if (rr_awready !== 4'(1 << er[k])) begin
        errs++;
        $display("FAIL qos_off_grant k%0d: got %b want %b", k, rr_awready, 4'(1 << er[k]));
      end
      qv[eq[k]] = 1'b0;
      rv[er[k]] = 1'b0;
      step();
    end
    m_awvalid  = '0;
    rr_awvalid = '0;
    #2;
    vecs++;
    if (s_aw[61:56] !== 6'b01_0001 || wq_full !== 1'b1) begin
      errs++;
      $display("FAIL qos_last_aw: id=%h full=%b want id=11 full=1", s_aw[61:56], wq_full);
    end
  endtask

  task automatic test_backpressure();
    logic [59:0] aw0, aw1;
    aw0 = mk_aw(4'h3, 32'hDEAD_0000, 8'd1, 4'd0);
    aw1 = mk_aw(4'h7, 32'hBEEF_0040, 8'd2, 4'd0);
    do_reset();
    set_aw(0, aw0);
    set_aw(1, aw1);
    m_awvalid = 4'b0011;
    s_awready = 1'b0;
    #2;
    vecs++;
    if (m_awready !== 4'b0001) begin
      errs++;
      $display("FAIL bp_first_grant: got %b want 0001", m_awready);
    end
    step();
    m_awvalid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #2;
      vecs++;
      if (s_awvalid !== 1'b1 || s_aw !== {2'd0, aw0} || m_awready !== 4'b0000) begin
        errs++;
        $display("FAIL bp_hold c%0d: vld=%b aw=%h rdy=%b want vld=1 aw=%h rdy=0000", c, s_awvalid, s_aw,
                 m_awready, {2'd0, aw0});
      end
      step();
    end
    s_awready = 1'b1;
    #2;
    vecs++;
    if (m_awready !== 4'b0010 || s_aw !== {2'd0, aw0}) begin
      errs++;
      $display("FAIL bp_release: rdy=%b aw=%h want rdy=0010 aw=%h", m_awready, s_aw, {2'd0, aw0});
    end
    step();
    m_awvalid = '0;
    #2;
    vecs++;
    if (s_awvalid !== 1'b1 || s_aw !== {2'd1, aw1}) begin
      errs++;
      $display("FAIL bp_next_aw: vld=%b aw=%h want vld=1 aw=%h", s_awvalid, s_aw, {2'd1, aw1});
    end
  endtask

  task automatic test_w_order();
    do_reset();
    s_awready = 1'b1;
    s_wready  = 1'b1;
    set_aw(2, mk_aw(4'd2, 32'h2000, 8'd3, 4'd0));
    set_aw(0, mk_aw(4'd0, 32'h0100, 8'd0, 4'd0));
    set_w(0, 64'hD0, 1'b1);
    m_wvalid  = 4'b0001;
    m_awvalid = 4'b0100;
    #2;
    vecs++;
    if (m_awready !== 4'b0100 || s_wvalid !== 1'b0 || m_wready !== 4'b0000) begin
      errs++;
      $display("FAIL wo_empty_stall: awrdy=%b wv=%b wrdy=%b want 0100/0/0000", m_awready, s_wvalid, m_wready);
    end
    step();
    m_awvalid = 4'b0001;
    for (int b = 1; b <= 4; b++) begin
      set_w(2, 64'h20 + 64'(b), b == 4);
      m_wvalid = 4'b0101;
      #2;
      if (b == 1) begin
        vecs++;
        if (m_awready !== 4'b0001) begin
          errs++;
          $display("FAIL wo_m0_aw: got %b want 0001", m_awready);
        end
      end
      vecs++;
      if (s_wvalid !== 1'b1 || m_wready !== 4'b0100 || s_w !== {64'h20 + 64'(b), 8'hFF, 1'(b == 4)}) begin
        errs++;
        $display("FAIL wo_m2_beat%0d: wv=%b wrdy=%b w=%h want wv=1 wrdy=0100 w=%h", b, s_wvalid, m_wready,
                 s_w, {64'h20 + 64'(b), 8'hFF, 1'(b == 4)});
      end
      step();
      m_awvalid = '0;
    end
    m_wvalid = 4'b0001;
    #2;
    vecs++;
    if (m_wready !== 4'b0001 || s_wvalid !== 1'b1 || s_w[72:9] !== 64'hD0) begin
      errs++;
      $display("FAIL wo_m0_beat: wrdy=%b wv=%b data=%h want 0001/1/d0", m_wready, s_wvalid, s_w[72:9]);
    end
    step();
    m_wvalid = '0;
    #2;
    vecs++;
    if (s_wvalid !== 1'b0 || m_wready !== 4'b0000) begin
      errs++;
      $display("FAIL wo_drained: wv=%b wrdy=%b want 0/0000", s_wvalid, m_wready);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    s_awready = 1'b1;
    s_wready  = 1'b1;
    for (int m = 0; m < 4; m++) set_aw(m, mk_aw(4'(m), 32'h40 * m, 8'd0, 4'd0));
    for (int m = 0; m < 4; m++) begin
      m_awvalid = 4'(1 << m);
      #2;
      vecs++;
      if (m_awready !== 4'(1 << m) || wq_full !== 1'b0) begin
        errs++;
        $display("FAIL ff_fill m%0d: rdy=%b full=%b want %b/0", m, m_awready, wq_full, 4'(1 << m));
      end
      step();
    end
    m_awvalid = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      #2;
      vecs++;
      if (wq_full !== 1'b1 || m_awready !== 4'b0000) begin
        errs++;
        $display("FAIL ff_blocked c%0d: full=%b rdy=%b want 1/0000", c, wq_full, m_awready);
      end
      step();
    end
    set_w(0, 64'hF0, 1'b1);
    m_wvalid = 4'b0001;
    #2;
    vecs++;
    if (m_wready !== 4'b0001 || m_awready !== 4'b0000) begin
      errs++;
      $display("FAIL ff_pop_cycle: wrdy=%b awrdy=%b want 0001/0000", m_wready, m_awready);
    end
    step();
    m_wvalid = '0;
    #2;
    vecs++;
    if (wq_full !== 1'b0 || m_awready !== 4'b0001) begin
      errs++;
      $display("FAIL ff_regrant: full=%b rdy=%b want 0/0001", wq_full, m_awready);
    end
    step();
    m_awvalid = '0;
    #2;
    vecs++;
    if (wq_full !== 1'b1 || m_awready !== 4'b0000) begin
      errs++;
      $display("FAIL ff_refull: full=%b rdy=%b want 1/0000", wq_full, m_awready);
    end
  endtask

  initial begin
    areset     = 1'b1;
    m_awvalid  = '0;
    rr_awvalid = '0;
    m_wvalid   = '0;
    m_aw       = '0;
    m_w        = '0;
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    test_reset();
    test_round_robin();
    test_qos();
    test_backpressure();
    test_w_order();
    test_fifo_full();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
